// File: rtl/rv32i_mem_responder_pkg.sv
// Shared definitions for the rv32i memory responder: size encodings, FSM states and
// small helpers for alignment checks and load extension.
package rv32i_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_END,
        WR_LO,
        WR_HI
    } state_e;

    // Reserved size is folded into the misalign check so it takes the same error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] sign_ext(input logic [15:0] value, input logic is_byte,
                                             input logic zero_ext);
        logic [31:0] result;
        if (is_byte) begin
            result = zero_ext ? {24'h000000, value[7:0]} : {{24{value[7]}}, value[7:0]};
        end else begin
            result = zero_ext ? {16'h0000, value} : {{16{value[15]}}, value};
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Picks the addressed byte or halfword out of one 16-bit memory word and extends it to 32 bits.
module rv32i_load_align
    import rv32i_mem_responder_pkg::*;
(
    input  logic [15:0] half,
    input  logic        byte_hi,
    input  logic        is_byte,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [15:0] shifted;

    always_comb begin
        shifted = byte_hi ? {8'h00, half[15:8]} : half;
        result  = sign_ext(shifted, is_byte, zero_ext);
    end

endmodule

// File: rtl/rv32i_mem_responder.sv
// Memory-side responder: serves one byte/half/word load or store at a time from a
// 16-bit synchronous SRAM, one little-endian halfword per access.
module rv32i_mem_responder
    import rv32i_mem_responder_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [XLEN-1:0]      req_addr_i,
    input  logic [XLEN-1:0]      req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [XLEN-1:0]      rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [1:0]           mem_be_o,
    output logic [15:0]          mem_wdata_o,
    input  logic [15:0]          mem_rdata_i
);

    state_e               state_q, state_d;
    logic [ADDR_BITS:0]   addr_q;
    size_e                size_q;
    logic                 unsigned_q;
    logic [XLEN-1:0]      wdata_q;
    logic [15:0]          lo_q;
    logic                 use_hi;
    logic                 accept_ok;
    logic [31:0]          aligned;
    logic [ADDR_BITS-1:0] hw;
    logic                 unused_addr_bits;

    // Address bits above the backing memory alias onto it.
    assign unused_addr_bits = ^req_addr_i[XLEN-1:ADDR_BITS+1];
    assign accept_ok        = req_valid_i && !is_misaligned(req_size_i, req_addr_i[1:0]);
    assign hw               = addr_q[ADDR_BITS:1];
    assign mem_addr_o       = use_hi ? hw + ADDR_BITS'(1) : hw;

    rv32i_load_align u_align (
        .half     (mem_rdata_i),
        .byte_hi  (addr_q[0]),
        .is_byte  (size_q == SZ_BYTE),
        .zero_ext (unsigned_q),
        .result   (aligned)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_be_o    = 2'b00;
        mem_wdata_o = 16'h0000;
        use_hi      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept_ok) state_d = req_write_i ? WR_LO : RD_LO;
            end
            RD_LO: begin
                mem_rd_o = 1'b1;
                state_d  = (size_q == SZ_WORD) ? RD_HI : RD_END;
            end
            RD_HI: begin
                mem_rd_o = 1'b1;
                use_hi   = 1'b1;
                state_d  = RD_END;
            end
            RD_END: state_d = IDLE;
            WR_LO: begin
                mem_wr_o = 1'b1;
                if (size_q == SZ_BYTE) begin
                    mem_be_o    = addr_q[0] ? 2'b10 : 2'b01;
                    mem_wdata_o = {wdata_q[7:0], wdata_q[7:0]};
                end else begin
                    mem_be_o    = 2'b11;
                    mem_wdata_o = wdata_q[15:0];
                end
                state_d = (size_q == SZ_WORD) ? WR_HI : IDLE;
            end
            WR_HI: begin
                mem_wr_o    = 1'b1;
                use_hi      = 1'b1;
                mem_be_o    = 2'b11;
                mem_wdata_o = wdata_q[31:16];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response is registered, so it appears in the cycle IDLE is re-entered.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            if (state_q == IDLE && req_valid_i) begin
                addr_q     <= req_addr_i[ADDR_BITS:0];
                size_q     <= size_e'(req_size_i);
                unsigned_q <= req_unsigned_i;
                wdata_q    <= req_wdata_i;
                if (!accept_ok) begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b1;
                end
            end
            if (state_q == RD_HI) lo_q <= mem_rdata_i;
            if (state_q == RD_END) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= (size_q == SZ_WORD) ? {mem_rdata_i, lo_q} : aligned;
            end
            if ((state_q == WR_LO && size_q != SZ_WORD) || state_q == WR_HI) begin
                rsp_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Scoreboard bench for rv32i_mem_responder: directed requests push expected memory strobes
// and responses; independent monitors pop and compare whenever the DUT presents them.
module tb_rv32i_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] mem [0:32767];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          cycle;
    } strobe_t;

    rsp_t        rsp_q[$];
    strobe_t     strobe_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held = '0;

    rv32i_mem_responder dut (
        .clk_i          (clk),
        .reset_i        (reset_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_addr_o     (mem_addr),
        .mem_rd_o       (mem_rd),
        .mem_wr_o       (mem_wr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_be[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check_output("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check_output("rsp_cycle", 32'(cyc), 32'(e.cycle));
                check_output("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check_output("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    // Memory strobe monitor
    always @(negedge clk) begin
        if (reset_n && (mem_rd || mem_wr)) begin
            check_output("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (strobe_q.size() == 0) begin
                check_output("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                strobe_t s;
                s = strobe_q.pop_front();
                check_output("strobe_cycle", 32'(cyc), 32'(s.cycle));
                check_output("strobe_kind", {31'd0, mem_wr}, {31'd0, s.wr});
                check_output("strobe_addr", {17'd0, mem_addr}, {17'd0, s.addr});
                if (s.wr) begin
                    check_output("strobe_be", {30'd0, mem_be}, {30'd0, s.be});
                    check_output("strobe_wdata", {16'd0, mem_wdata}, {16'd0, s.wdata});
                end
            end
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output int a);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check_output("ready_timeout", 32'd0, 32'd1);
        a            = cyc;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    function automatic strobe_t mk_strobe(input logic wr, input logic [14:0] addr,
                                          input logic [1:0] be, input logic [15:0] wdata,
                                          input int cycle);
        strobe_t s;
        s.wr = wr; s.addr = addr; s.be = be; s.wdata = wdata; s.cycle = cycle;
        return s;
    endfunction

    function automatic rsp_t mk_rsp(input logic [31:0] rdata, input logic err, input int cycle);
        rsp_t r;
        r.rdata = rdata; r.err = err; r.cycle = cycle;
        return r;
    endfunction

    task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [14:0] hw_lo, input logic [31:0] exp);
        int a;
        apply_stimulus(1'b0, size, uns, addr, 32'h0, a);
        strobe_q.push_back(mk_strobe(1'b0, hw_lo, 2'b00, 16'h0, a + 1));
        if (size == 2'b10) begin
            strobe_q.push_back(mk_strobe(1'b0, hw_lo + 15'd1, 2'b00, 16'h0, a + 2));
            rsp_q.push_back(mk_rsp(exp, 1'b0, a + 4));
        end else begin
            rsp_q.push_back(mk_rsp(exp, 1'b0, a + 3));
        end
        held = exp;
    endtask

    task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [14:0] hw_lo, input logic [1:0] be, input logic [15:0] wd_lo);
        int a;
        apply_stimulus(1'b1, size, 1'b0, addr, wdata, a);
        strobe_q.push_back(mk_strobe(1'b1, hw_lo, be, wd_lo, a + 1));
        if (size == 2'b10) begin
            strobe_q.push_back(mk_strobe(1'b1, hw_lo + 15'd1, 2'b11, wdata[31:16], a + 2));
            rsp_q.push_back(mk_rsp(held, 1'b0, a + 3));
        end else begin
            rsp_q.push_back(mk_rsp(held, 1'b0, a + 2));
        end
    endtask

    task automatic do_error(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        int a;
        apply_stimulus(wr, size, 1'b0, addr, 32'h1111_2222, a);
        rsp_q.push_back(mk_rsp(held, 1'b1, a + 1));
    endtask

    initial begin
        int a;
        int drain;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[15'h0082] = 16'hBEEF;
        mem[15'h0083] = 16'hDEAD;
        mem[15'h0008] = 16'h80AA;

        #2;
        check_output("reset_ready", {31'd0, req_ready}, 32'd1);
        check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("reset_rdata", rsp_rdata, 32'd0);
        check_output("reset_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check_output("reset_mem_addr", {17'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_load(2'b10, 1'b0, 32'h0000_0104, 15'h0082, 32'hDEAD_BEEF);
        do_load(2'b00, 1'b0, 32'h0000_0011, 15'h0008, 32'hFFFF_FF80);
        do_load(2'b00, 1'b1, 32'h0000_0011, 15'h0008, 32'h0000_0080);
        do_load(2'b01, 1'b0, 32'h0000_0010, 15'h0008, 32'hFFFF_80AA);
        do_load(2'b01, 1'b1, 32'h0000_0010, 15'h0008, 32'h0000_80AA);
        do_load(2'b00, 1'b0, 32'h0000_0010, 15'h0008, 32'hFFFF_FFAA);
        do_store(2'b00, 32'h0000_0003, 32'hFFFF_FF5A, 15'h0001, 2'b10, 16'h5A5A);
        do_load(2'b01, 1'b0, 32'h0000_0002, 15'h0001, 32'h0000_5A00);
        do_store(2'b10, 32'h0000_FFFC, 32'h1234_5678, 15'h7FFE, 2'b11, 16'h5678);
        do_load(2'b10, 1'b0, 32'h0000_FFFC, 15'h7FFE, 32'h1234_5678);
        do_load(2'b10, 1'b0, 32'h0001_0104, 15'h0082, 32'hDEAD_BEEF);
        do_load(2'b00, 1'b1, 32'h0000_FFFD, 15'h7FFE, 32'h0000_0056);
        do_store(2'b01, 32'h0000_0020, 32'hFFFF_CAFE, 15'h0010, 2'b11, 16'hCAFE);
        do_load(2'b01, 1'b0, 32'h0000_0020, 15'h0010, 32'hFFFF_CAFE);

        do_error(1'b0, 2'b01, 32'h0000_0101);
        do_error(1'b1, 2'b10, 32'h0000_0102);
        do_error(1'b0, 2'b11, 32'h0000_0100);
        do_error(1'b1, 2'b11, 32'h0000_0100);

        // Abort a word load during its second read cycle.
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, a);
        strobe_q.push_back(mk_strobe(1'b0, 15'h0082, 2'b00, 16'h0, a + 1));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rsp_q.delete();
        held = 32'h0;
        #1;
        check_output("abort_ready", {31'd0, req_ready}, 32'd1);
        check_output("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_output("abort_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_output("abort_ready_after", {31'd0, req_ready}, 32'd1);

        do_load(2'b00, 1'b1, 32'h0000_0011, 15'h0008, 32'h0000_0080);

        drain = 0;
        while ((rsp_q.size() != 0 || strobe_q.size() != 0) && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        repeat (2) @(negedge clk);
        check_output("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check_output("strobe_queue_empty", 32'(strobe_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
